// File: rtl/core_pkg.sv
// Shared types and default parameters for the core run controller.
package core_pkg;

    localparam int INSTR_WIDTH_DEF = 9;
    localparam int CNT_WIDTH_DEF   = 16;
    localparam int NUM_PROGS_DEF   = 3;

    localparam logic [NUM_PROGS_DEF*INSTR_WIDTH_DEF-1:0] PROG_BASE_DEF = '0;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_RUN   = 3'd2,
        S_DONE  = 3'd3,
        S_ABORT = 3'd4
    } run_state_t;

endpackage

// File: rtl/run_ctrl_sat_counter.sv
// Up-counter with synchronous clear that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + WIDTH'(1'b1);
        end
    end

endmodule

// File: rtl/run_ctrl.sv
// Run controller: program select, fetch start pulse, retire/cycle counters, halt and watchdog.
module run_ctrl
    import core_pkg::*;
#(
    parameter int                             INSTR_WIDTH = INSTR_WIDTH_DEF,
    parameter int                             CNT_WIDTH   = CNT_WIDTH_DEF,
    parameter int                             NUM_PROGS   = NUM_PROGS_DEF,
    parameter logic [NUM_PROGS*INSTR_WIDTH-1:0] PROG_BASE = PROG_BASE_DEF,
    parameter logic [CNT_WIDTH-1:0]           TIMEOUT     = '1,
    localparam int                            SEL_WIDTH   = (NUM_PROGS > 1) ? $clog2(NUM_PROGS) : 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [SEL_WIDTH-1:0]   prog_sel,
    input  logic                   halt,
    input  logic                   retire,
    output logic                   core_start,
    output logic [INSTR_WIDTH-1:0] start_addr,
    output logic                   busy,
    output logic                   done,
    output logic                   timed_out,
    output logic [CNT_WIDTH-1:0]   instr_count,
    output logic [CNT_WIDTH-1:0]   cycle_count
);

    localparam logic [CNT_WIDTH-1:0] TIMEOUT_LAST  = TIMEOUT - CNT_WIDTH'(1'b1);
    localparam bit                   WDOG_EN       = (TIMEOUT != '0);
    localparam logic [SEL_WIDTH:0]   NUM_PROGS_EXT = (SEL_WIDTH+1)'(NUM_PROGS);
    localparam logic [SEL_WIDTH-1:0] LAST_SEL      = SEL_WIDTH'(NUM_PROGS - 1);

    run_state_t             state;
    run_state_t             state_next;
    logic                   accept;
    logic                   running;
    logic                   timeout_hit;
    logic [SEL_WIDTH-1:0]   sel_clamped;
    logic [INSTR_WIDTH-1:0] entry_addr;

    assign running     = (state == S_RUN);
    assign accept      = start && ((state == S_IDLE) || (state == S_DONE) || (state == S_ABORT));
    assign timeout_hit = WDOG_EN && (cycle_count == TIMEOUT_LAST);

    // Out-of-range selections fall back to the last program rather than faulting.
    assign sel_clamped = ({1'b0, prog_sel} >= NUM_PROGS_EXT) ? LAST_SEL : prog_sel;
    assign entry_addr  = PROG_BASE[int'(sel_clamped)*INSTR_WIDTH +: INSTR_WIDTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            start_addr <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                start_addr <= entry_addr;
            end
        end
    end

    always_comb begin
        // NOTE: defaulting state_next first keeps every path assigned, so no latch is inferred.
        state_next = state;
        unique case (state)
            S_IDLE, S_DONE, S_ABORT: if (start) state_next = S_LOAD;
            S_LOAD:                  state_next = S_RUN;
            S_RUN: begin
                if (halt)             state_next = S_DONE;
                else if (timeout_hit) state_next = S_ABORT;
            end
            default:                 state_next = S_IDLE;
        endcase
    end

    always_comb begin
        core_start = (state == S_LOAD);
        busy       = (state == S_LOAD) || (state == S_RUN);
        done       = (state == S_DONE);
        timed_out  = (state == S_ABORT);
    end

    sat_counter #(.WIDTH(CNT_WIDTH)) u_cycle_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (accept),
        .inc   (running),
        .count (cycle_count)
    );

    // The HALT instruction itself is never counted as retired.
    sat_counter #(.WIDTH(CNT_WIDTH)) u_instr_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (accept),
        .inc   (running && retire && !halt),
        .count (instr_count)
    );

endmodule

// File: tb/tb_run_ctrl.sv
// Directed bench for run_ctrl: three configurations share one stimulus stream.
module tb_run_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [1:0] prog_sel;
    logic       halt;
    logic       retire;

    logic        core_start_a, busy_a, done_a, timed_out_a;
    logic [8:0]  start_addr_a;
    logic [15:0] instr_a, cycle_a;

    logic        core_start_b, busy_b, done_b, timed_out_b;
    logic [8:0]  start_addr_b;
    logic [15:0] instr_b, cycle_b;

    logic        core_start_c, busy_c, done_c, timed_out_c;
    logic [8:0]  start_addr_c;
    logic [3:0]  instr_c, cycle_c;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    run_ctrl #(
        .INSTR_WIDTH(9), .CNT_WIDTH(16), .NUM_PROGS(3),
        .PROG_BASE({9'd40, 9'd20, 9'd0}), .TIMEOUT(16'hFFFF)
    ) u_dut_a (
        .clk(clk), .rst_n(rst_n), .start(start), .prog_sel(prog_sel), .halt(halt), .retire(retire),
        .core_start(core_start_a), .start_addr(start_addr_a), .busy(busy_a), .done(done_a),
        .timed_out(timed_out_a), .instr_count(instr_a), .cycle_count(cycle_a)
    );

    run_ctrl #(
        .INSTR_WIDTH(9), .CNT_WIDTH(16), .NUM_PROGS(3),
        .PROG_BASE({9'd40, 9'd20, 9'd0}), .TIMEOUT(16'd8)
    ) u_dut_b (
        .clk(clk), .rst_n(rst_n), .start(start), .prog_sel(prog_sel), .halt(halt), .retire(retire),
        .core_start(core_start_b), .start_addr(start_addr_b), .busy(busy_b), .done(done_b),
        .timed_out(timed_out_b), .instr_count(instr_b), .cycle_count(cycle_b)
    );

    run_ctrl #(
        .INSTR_WIDTH(9), .CNT_WIDTH(4), .NUM_PROGS(3),
        .PROG_BASE({9'd40, 9'd20, 9'd0}), .TIMEOUT(4'd0)
    ) u_dut_c (
        .clk(clk), .rst_n(rst_n), .start(start), .prog_sel(prog_sel), .halt(halt), .retire(retire),
        .core_start(core_start_c), .start_addr(start_addr_c), .busy(busy_c), .done(done_c),
        .timed_out(timed_out_c), .instr_count(instr_c), .cycle_count(cycle_c)
    );

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        assert (observed === expected) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Advance n rising edges and land 1 time unit after the last one.
    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: bench did not reach its summary");
        $fatal(1, "bench time limit expired");
    end

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        prog_sel = 2'd0;
        halt     = 1'b0;
        retire   = 1'b0;
        #1;
        check("rst_busy",       busy_a,       0);
        check("rst_core_start", core_start_a, 0);
        check("rst_done",       done_a,       0);
        check("rst_timed_out",  timed_out_a,  0);
        check("rst_start_addr", start_addr_a, 0);
        check("rst_instr",      instr_a,      0);
        check("rst_cycle",      cycle_a,      0);
        tick(2);
        rst_n = 1'b1;
        tick();
        check("idle_busy", busy_a, 0);

        // Normal run: prog 1 -> entry 20, five retires then HALT (retire on the HALT cycle is ignored).
        prog_sel = 2'd1;
        start    = 1'b1;
        tick();
        check("load_core_start", core_start_a, 1);
        check("load_busy",       busy_a,       1);
        check("load_start_addr", start_addr_a, 20);
        check("load_cycle",      cycle_a,      0);
        start  = 1'b0;
        retire = 1'b1;
        tick();
        check("run_core_start_low", core_start_a, 0);
        check("run_first_cycle",    cycle_a,      0);
        tick(5);
        check("run_instr5", instr_a, 5);
        check("run_cycle5", cycle_a, 5);
        halt = 1'b1;
        tick();
        halt   = 1'b0;
        retire = 1'b0;
        check("halt_done",       done_a,       1);
        check("halt_busy",       busy_a,       0);
        check("halt_timed_out",  timed_out_a,  0);
        check("halt_instr",      instr_a,      5);
        check("halt_cycle",      cycle_a,      6);
        check("halt_start_addr", start_addr_a, 20);
        retire = 1'b1;
        tick(2);
        retire = 1'b0;
        check("done_hold_instr", instr_a, 5);
        check("done_hold_cycle", cycle_a, 6);
        check("done_hold_flag",  done_a,  1);

        // Restart from DONE with out-of-range selection 3 -> clamped to prog 2 (entry 40).
        prog_sel = 2'd3;
        start    = 1'b1;
        tick();
        check("restart_done_clr", done_a,       0);
        check("restart_load",     core_start_a, 1);
        check("restart_addr",     start_addr_a, 40);
        check("restart_instr",    instr_a,      0);
        check("restart_cycle",    cycle_a,      0);
        start  = 1'b0;
        retire = 1'b1;
        tick();
        prog_sel = 2'd0;
        start    = 1'b1;
        tick(2);
        check("ign_core_start", core_start_a, 0);
        check("ign_busy",       busy_a,       1);
        check("ign_addr",       start_addr_a, 40);
        check("ign_instr",      instr_a,      2);
        check("ign_cycle",      cycle_a,      2);
        start = 1'b0;
        halt  = 1'b1;
        tick();
        halt   = 1'b0;
        retire = 1'b0;
        check("ign_done",        done_a,  1);
        check("ign_final_instr", instr_a, 2);
        check("ign_final_cycle", cycle_a, 3);

        // Asynchronous reset in the middle of a run clears everything without a clock edge.
        prog_sel = 2'd0;
        start    = 1'b1;
        tick();
        start  = 1'b0;
        retire = 1'b1;
        tick(3);
        check("mid_busy_before",  busy_a,  1);
        check("mid_instr_before", instr_a, 2);
        #3;
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy",  busy_a,       0);
        check("mid_rst_done",  done_a,       0);
        check("mid_rst_to",    timed_out_a,  0);
        check("mid_rst_instr", instr_a,      0);
        check("mid_rst_cycle", cycle_a,      0);
        check("mid_rst_addr",  start_addr_a, 0);
        rst_n  = 1'b1;
        retire = 1'b0;
        tick();
        check("mid_rst_idle", busy_a, 0);

        // Watchdog (TIMEOUT=8): abort after the 8th RUN cycle.
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick(7);
        check("wd_busy_pre",  busy_b,      1);
        check("wd_cycle_pre", cycle_b,     7);
        check("wd_to_pre",    timed_out_b, 0);
        tick();
        check("wd_timed_out", timed_out_b,  1);
        check("wd_busy",      busy_b,       0);
        check("wd_done",      done_b,       0);
        check("wd_cycle",     cycle_b,      8);
        check("wd_addr",      start_addr_b, 0);
        tick(2);
        check("wd_hold_flag",  timed_out_b, 1);
        check("wd_hold_cycle", cycle_b,     8);
        do_reset();
        tick();

        // HALT on the same cycle the watchdog would fire: halt wins.
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick(7);
        halt = 1'b1;
        tick();
        halt = 1'b0;
        check("tie_done",      done_b,      1);
        check("tie_timed_out", timed_out_b, 0);
        check("tie_cycle",     cycle_b,     8);
        do_reset();
        tick();

        // Saturation (CNT_WIDTH=4, watchdog off): counters stop at 15.
        start = 1'b1;
        tick();
        start  = 1'b0;
        retire = 1'b1;
        tick();
        tick(14);
        check("sat_instr14", instr_c, 14);
        tick(6);
        retire = 1'b0;
        check("sat_instr", instr_c,     15);
        check("sat_cycle", cycle_c,     15);
        check("sat_busy",  busy_c,      1);
        check("sat_no_to", timed_out_c, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
